// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: MSB-first bit stream in, comma-aligned bytes out.
// Each byte and its valid flag are held for a full 8-cycle byte period.
module serial_paralelo #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned COMMA_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  comma_cnt_q, comma_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        active_q, active_d;
    logic        byte_strobe_q, byte_strobe_d;

    logic [7:0]  nxt;
    logic        boundary;
    logic        is_comma;

    assign nxt      = {sr_q[6:0], data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_comma = (nxt == COMMA);

    always_comb begin
        state_d       = state_q;
        sr_d          = nxt;
        bit_cnt_d     = bit_cnt_q + 3'd1;
        comma_cnt_d   = comma_cnt_q;
        data_out_d    = data_out_q;
        valid_out_d   = valid_out_q;
        active_d      = active_q;
        byte_strobe_d = 1'b0;

        case (state_q)
            SEARCH: begin
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = 4'd1;
                    if (COMMA_COUNT == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        if (comma_cnt_d == 4'(COMMA_COUNT)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Slip detected: hunt resumes from the next edge, so a
                        // comma straddling this boundary is not matched here.
                        state_d     = SEARCH;
                        comma_cnt_d = '0;
                        bit_cnt_d   = '0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    byte_strobe_d = 1'b1;
                    if (is_comma) begin
                        valid_out_d = 1'b0;
                    end else begin
                        data_out_d  = nxt;
                        valid_out_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q       <= SEARCH;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            comma_cnt_q   <= '0;
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            active_q      <= 1'b0;
            byte_strobe_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            comma_cnt_q   <= comma_cnt_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            active_q      <= active_d;
            byte_strobe_q <= byte_strobe_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_out_q;
    assign active      = active_q;
    assign byte_strobe = byte_strobe_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: lock, slip, insufficient commas,
// boundary-straddling comma data, async reset, and a single-comma build.
module tb_serial_paralelo;

    logic       clk_32f;
    logic       reset;
    logic       reset1;
    logic       data_in;

    logic [7:0] data_out, data_out1;
    logic       valid_out, valid_out1;
    logic       active, active1;
    logic       byte_strobe, byte_strobe1;

    int total = 0;
    int bad = 0;
    int strobe_hits = 0;
    int quiet_viol = 0;

    serial_paralelo #(.COMMA(8'hBC), .COMMA_COUNT(4)) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .byte_strobe (byte_strobe)
    );

    serial_paralelo #(.COMMA(8'hBC), .COMMA_COUNT(1)) dut1 (
        .clk_32f     (clk_32f),
        .reset       (reset1),
        .data_in     (data_in),
        .data_out    (data_out1),
        .valid_out   (valid_out1),
        .active      (active1),
        .byte_strobe (byte_strobe1)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, let one rising edge sample it, observe 1 time unit later.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (byte_strobe) strobe_hits++;
        if (active || valid_out || byte_strobe) quiet_viol++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        reset1  = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        chk("rst_data",   int'(data_out),    'h00);
        chk("rst_valid",  int'(valid_out),   0);
        chk("rst_active", int'(active),      0);
        chk("rst_strobe", int'(byte_strobe), 0);
        reset = 1'b1;

        // Lock and first byte
        repeat (3) send_bit(1'b0);
        repeat (3) send_byte(8'hBC);
        chk("lock_pre_active", int'(active), 0);
        send_byte(8'hBC);
        chk("lock_active",  int'(active),      1);
        chk("lock_valid",   int'(valid_out),   0);
        chk("lock_strobe",  int'(byte_strobe), 0);
        strobe_hits = 0;
        send_byte(8'hA5);
        chk("a5_data",   int'(data_out),  'hA5);
        chk("a5_valid",  int'(valid_out), 1);
        chk("a5_strobe", strobe_hits,     1);
        strobe_hits = 0;
        send_byte(8'hBC);
        chk("idle_data",   int'(data_out),  'hA5);
        chk("idle_valid",  int'(valid_out), 0);
        chk("idle_strobe", strobe_hits,     1);
        strobe_hits = 0;
        send_byte(8'h3C);
        chk("3c_data",   int'(data_out),  'h3C);
        chk("3c_valid",  int'(valid_out), 1);
        chk("3c_strobe", strobe_hits,     1);

        // Comma pattern straddling a boundary is data once active
        send_byte(8'h5E);
        chk("5e_data",  int'(data_out),  'h5E);
        chk("5e_valid", int'(valid_out), 1);
        send_byte(8'h00);
        chk("00_data",   int'(data_out),  'h00);
        chk("00_valid",  int'(valid_out), 1);
        chk("00_active", int'(active),    1);

        // Asynchronous reset mid-byte
        send_byte(8'hA5);
        chk("pre_rst_data", int'(data_out), 'hA5);
        #3;
        reset = 1'b0;
        #1;
        chk("async_data",   int'(data_out),    'h00);
        chk("async_valid",  int'(valid_out),   0);
        chk("async_active", int'(active),      0);
        chk("async_strobe", int'(byte_strobe), 0);
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
        repeat (3) send_byte(8'hBC);
        chk("relock_pre_active", int'(active), 0);
        send_byte(8'hBC);
        chk("relock_active", int'(active), 1);
        send_byte(8'h77);
        chk("relock_data",  int'(data_out),  'h77);
        chk("relock_valid", int'(valid_out), 1);

        // Broken alignment: one extra bit after two commas
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_bit(1'b0);
        send_byte(8'hBC);
        chk("slip_active1", int'(active), 0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("slip_active3", int'(active), 0);
        send_byte(8'hBC);
        chk("slip_lock", int'(active), 1);
        send_byte(8'h77);
        chk("slip_data",  int'(data_out),  'h77);
        chk("slip_valid", int'(valid_out), 1);

        // Never enough consecutive commas
        do_reset();
        quiet_viol = 0;
        for (int g = 0; g < 4; g++) begin
            repeat (3) send_byte(8'hBC);
            send_byte(8'h12);
        end
        chk("short_quiet",  quiet_viol,   0);
        chk("short_active", int'(active), 0);

        // Single-comma build
        reset1 = 1'b1;
        send_byte(8'hBC);
        chk("cc1_active", int'(active1),      1);
        chk("cc1_valid0", int'(valid_out1),   0);
        chk("cc1_strb0",  int'(byte_strobe1), 0);
        send_byte(8'hC3);
        chk("cc1_data",  int'(data_out1),    'hC3);
        chk("cc1_valid", int'(valid_out1),   1);
        chk("cc1_strb",  int'(byte_strobe1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Serial-to-parallel receiver clocked by clk_32f, the fastest clock produced by the clock generator stage. Its byte boundary strobe is phase-equivalent to one clk_4f period.
- Deserialises a 1-bit MSB-first stream into bytes.
- Acquires byte alignment by detecting consecutive COMMA (idle) symbols.
- Presents each received byte, with a valid flag, held for a full 8-cycle byte period so clk_4f-domain logic can sample it.

Parameters:
- COMMA, 8'hBC: idle/alignment symbol.
- COMMA_COUNT, 4: consecutive aligned commas required to declare link active; legal range 1..15.

Ports:
- clk_32f  input  1  bit clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  1  serial data, MSB first, one bit per clk_32f edge.
- data_out  output  8  last received non-comma byte.
- valid_out  output  1  1 = the current byte period carries data; 0 = comma or not active.
- active  output  1  alignment achieved; sticky until reset.
- byte_strobe  output  1  one-cycle pulse on each byte boundary while active.

Behaviour:
- Reset (reset=0, asynchronous), all values 0:
  - Outputs: data_out=8'h00, valid_out, active, byte_strobe.
  - Internal: shift register sr[7:0], bit_cnt[2:0], comma_cnt, state=SEARCH.
  - All state resumes on the first rising clk_32f edge after reset=1.
- Every edge: nxt = {sr[6:0], data_in}; sr <= nxt. nxt is the byte ending with the bit sampled this edge.
- State SEARCH (bit-granular hunt):
  - If nxt==COMMA: bit_cnt<=0, comma_cnt<=1. Go to ACTIVE if COMMA_COUNT==1, else ALIGN.
  - Otherwise remain in SEARCH; bit_cnt and comma_cnt are don't-care but held at 0.
  - Because sr resets to 0, the earliest possible detection is the 8th post-reset edge.
- State ALIGN:
  - bit_cnt increments mod 8 every edge. A boundary is an edge where bit_cnt==7 (8 bits after the previous comma).
  - At a boundary with nxt==COMMA: comma_cnt+1. If the new count equals COMMA_COUNT, go to ACTIVE and set active<=1 on that same edge.
  - At a boundary with nxt!=COMMA: go to SEARCH, comma_cnt<=0. A comma straddling this boundary is not re-checked until the next edge.
  - Outputs stay at reset values in ALIGN.
- State ACTIVE:
  - bit_cnt continues mod 8; boundary definition as in ALIGN.
  - At a boundary: byte_strobe<=1.
    - nxt==COMMA: valid_out<=0, data_out holds its previous value.
    - Otherwise: data_out<=nxt, valid_out<=1.
  - Non-boundary edges: byte_strobe<=0; data_out and valid_out hold, giving stable values for 8 cycles.
  - Latency: data_out updates on the same edge that samples the byte's LSB (0 cycles after the last bit, registered).
  - No loss-of-lock detection: ACTIVE exits only via reset. A comma pattern spanning a boundary while ACTIVE is treated as data.
- active is registered and never deasserts without reset.
- Reset asserted mid-byte in any state: immediate return to reset values. The partial byte is discarded and realignment restarts from SEARCH.

Test Plan:
- Lock and first byte:
  - Stimulus: hold reset=0 for 2 edges, release, drive 3 bits of 0, then BC,BC,BC,BC,A5,BC,3C.
  - Required: active=1 on edge 35 (after release).
  - Edge 43: data_out=A5, valid_out=1, byte_strobe pulse.
  - Edge 51: valid_out=0, data_out=A5.
  - Edge 59: data_out=3C, valid_out=1.
  - byte_strobe high for exactly one cycle at each of edges 43, 51, 59.
- Broken alignment:
  - Stimulus: BC,BC, one extra 0 bit, then BC×4, 77.
  - Required: the slip returns the block to SEARCH with active=0.
  - Lock occurs only after 4 fresh commas; then data_out=77, valid_out=1.
- Insufficient commas:
  - Stimulus: BC×3 then 12, repeated 4 times.
  - Required: active, valid_out and byte_strobe remain 0 throughout.
- Unaligned comma-like data:
  - Stimulus: after lock, send 5E,00 (bit string contains BC across the boundary).
  - Required: data_out=5E then 00, valid_out=1 for both; no state change.
- Reset mid-operation:
  - Stimulus: while ACTIVE with data_out=A5, pull reset=0 mid-byte (not on a clock edge).
  - Required: data_out=00 and valid_out=active=byte_strobe=0 immediately, without a clock.
  - After release, relock requires COMMA_COUNT commas again.
- COMMA_COUNT=1 build:
  - Stimulus: single BC followed by C3.
  - Required: active=1 on the comma's last-bit edge; data_out=C3 with valid_out=1 8 edges later.
